// File: rtl/rv_pkg.sv
// ============================================================================
// Module : rv_pkg
// Brief  : RISC-V opcode constants and immediate-format encodings
// Rev    : 1.0
// ============================================================================
`default_nettype none

package rv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_OP32   = 7'b0111011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_Z    = 3'd5,
        IMM_NONE = 3'd7
    } imm_type_e;

endpackage

`default_nettype wire

// File: rtl/imm_gen_pipe_decode.sv
// ============================================================================
// Module : imm_decode
// Brief  : combinational instruction-format classifier and immediate extender
// Rev    : 1.0
// ============================================================================
`default_nettype none

module imm_decode
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_type_e       imm_type,
    output logic            illegal
);

    localparam bit c_IS64 = (XLEN == 64);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [5:0] w_shamt;
    logic [5:0] w_shamt32;
    logic       w_is_shift;

    assign w_opcode   = instr[6:0];
    assign w_funct3   = instr[14:12];
    // RV32 shifts carry only 5 shamt bits, so bit 25 must not leak into imm
    assign w_shamt32  = {1'b0, instr[24:20]};
    assign w_shamt    = c_IS64 ? instr[25:20] : w_shamt32;
    assign w_is_shift = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);

    always_comb begin
        imm      = '0;
        imm_type = IMM_NONE;
        illegal  = 1'b0;
        case (w_opcode)
            OP_LOAD, OP_FENCE, OP_JALR: begin
                imm_type = IMM_I;
                imm      = XLEN'($signed(instr[31:20]));
            end
            OP_IMM: begin
                imm_type = IMM_I;
                imm      = w_is_shift ? XLEN'(w_shamt) : XLEN'($signed(instr[31:20]));
            end
            OP_IMM32: begin
                if (c_IS64) begin
                    imm_type = IMM_I;
                    imm      = w_is_shift ? XLEN'(w_shamt32) : XLEN'($signed(instr[31:20]));
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_STORE: begin
                imm_type = IMM_S;
                imm      = XLEN'($signed({instr[31:25], instr[11:7]}));
            end
            OP_BRANCH: begin
                imm_type = IMM_B;
                imm      = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            end
            OP_LUI, OP_AUIPC: begin
                imm_type = IMM_U;
                imm      = XLEN'($signed({instr[31:12], 12'b0}));
            end
            OP_JAL: begin
                imm_type = IMM_J;
                imm      = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            end
            OP_SYSTEM: begin
                if (w_funct3[2]) begin
                    imm_type = IMM_Z;
                    imm      = XLEN'(instr[19:15]);
                end else if (w_funct3 != 3'b000) begin
                    imm_type = IMM_I;
                    imm      = XLEN'(instr[31:20]);
                end else begin
                    imm_type = IMM_I;
                    imm      = XLEN'($signed(instr[31:20]));
                end
            end
            OP_OP: begin
                imm_type = IMM_NONE;
            end
            OP_OP32: begin
                illegal = !c_IS64;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/imm_gen_pipe.sv
// ============================================================================
// Module : imm_gen_pipe
// Brief  : registered immediate generator with 2-entry output/skid buffer
// Rev    : 1.0
// ============================================================================
`default_nettype none

module imm_gen_pipe
    import rv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [2:0]       imm_type,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_count
);

    logic [XLEN-1:0]  w_dec_imm;
    imm_type_e        w_dec_type;
    logic             w_dec_ill;

    logic             r_in_ready;
    logic             r_out_valid;
    logic [XLEN-1:0]  r_out_imm;
    imm_type_e        r_out_type;
    logic             r_out_ill;
    logic             r_skid_valid;
    logic [XLEN-1:0]  r_skid_imm;
    imm_type_e        r_skid_type;
    logic             r_skid_ill;
    logic [CNT_W-1:0] r_cnt;

    logic             w_in_xfer;
    logic             w_skid_next;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr    (instr),
        .imm      (w_dec_imm),
        .imm_type (w_dec_type),
        .illegal  (w_dec_ill)
    );

    assign w_in_xfer   = in_valid && r_in_ready;
    // skid occupancy after this edge; in_ready is its registered inverse
    assign w_skid_next = r_skid_valid ? !out_ready
                                      : (w_in_xfer && r_out_valid && !out_ready);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_in_ready   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_imm    <= '0;
            r_out_type   <= IMM_NONE;
            r_out_ill    <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_imm   <= '0;
            r_skid_type  <= IMM_NONE;
            r_skid_ill   <= 1'b0;
            r_cnt        <= '0;
        end else begin
            if (r_skid_valid) begin
                if (out_ready) begin
                    r_out_imm    <= r_skid_imm;
                    r_out_type   <= r_skid_type;
                    r_out_ill    <= r_skid_ill;
                    r_skid_valid <= 1'b0;
                end
            end else if (w_in_xfer) begin
                if (!r_out_valid || out_ready) begin
                    r_out_valid <= 1'b1;
                    r_out_imm   <= w_dec_imm;
                    r_out_type  <= w_dec_type;
                    r_out_ill   <= w_dec_ill;
                end else begin
                    r_skid_valid <= 1'b1;
                    r_skid_imm   <= w_dec_imm;
                    r_skid_type  <= w_dec_type;
                    r_skid_ill   <= w_dec_ill;
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            r_in_ready <= !w_skid_next;
            if (w_in_xfer && w_dec_ill && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign in_ready      = r_in_ready;
    assign out_valid     = r_out_valid;
    assign imm           = r_out_imm;
    assign imm_type      = r_out_type;
    assign illegal       = r_out_ill;
    assign illegal_count = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
// ============================================================================
// Module : tb_imm_gen_pipe
// Brief  : scoreboard bench for imm_gen_pipe (RV32, RV64 and 2-bit counter)
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_imm_gen_pipe;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  typ;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  iv;
    logic [2:0]  ordy;
    wire  [2:0]  ir;
    wire  [2:0]  ov;
    logic [31:0] ins0, ins1, ins2;
    wire  [31:0] imm0, imm2;
    wire  [63:0] imm1;
    wire  [2:0]  t0, t1, t2;
    wire         il0, il1, il2;
    wire  [15:0] c0, c1;
    wire  [1:0]  c2;

    int   total = 0;
    int   bad   = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .CNT_W(16)) u32 (
        .clk(clk), .reset(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .instr(ins0),
        .out_valid(ov[0]), .out_ready(ordy[0]), .imm(imm0), .imm_type(t0),
        .illegal(il0), .illegal_count(c0)
    );

    imm_gen_pipe #(.XLEN(64), .CNT_W(16)) u64 (
        .clk(clk), .reset(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .instr(ins1),
        .out_valid(ov[1]), .out_ready(ordy[1]), .imm(imm1), .imm_type(t1),
        .illegal(il1), .illegal_count(c1)
    );

    imm_gen_pipe #(.XLEN(32), .CNT_W(2)) uc2 (
        .clk(clk), .reset(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .instr(ins2),
        .out_valid(ov[2]), .out_ready(ordy[2]), .imm(imm2), .imm_type(t2),
        .illegal(il2), .illegal_count(c2)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send(input int k, input logic [31:0] w, input logic [63:0] e_imm,
                        input logic [2:0] e_t, input logic e_il);
        exp_t e;
        int   n;
        @(posedge clk); #1;
        iv[k] = 1'b1;
        if (k == 0) ins0 = w; else if (k == 1) ins1 = w; else ins2 = w;
        n = 0;
        while (!ir[k] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ir[k]) begin
            chk("send_timeout", 64'(ir[k]), 64'd1);
            iv[k] = 1'b0;
        end else begin
            e.imm = e_imm;
            e.typ = e_t;
            e.ill = e_il;
            if (k == 0) q0.push_back(e);
            else if (k == 1) q1.push_back(e);
        end
    endtask

    task automatic idle(input int k);
        @(posedge clk); #1;
        iv[k] = 1'b0;
    endtask

    // Scoreboard monitors: pop one expectation per output transfer
    always @(negedge clk) begin
        if (rst_n && ov[0] && ordy[0]) begin
            if (q0.size() == 0) begin
                chk("m32_unexpected_output", 64'(q0.size()), 64'd1);
            end else begin
                e0 = q0.pop_front();
                chk("m32_imm", {32'b0, imm0}, {32'b0, e0.imm[31:0]});
                chk("m32_type", 64'(t0), 64'(e0.typ));
                chk("m32_illegal", 64'(il0), 64'(e0.ill));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ov[1] && ordy[1]) begin
            if (q1.size() == 0) begin
                chk("m64_unexpected_output", 64'(q1.size()), 64'd1);
            end else begin
                e1 = q1.pop_front();
                chk("m64_imm", imm1, e1.imm);
                chk("m64_type", 64'(t1), 64'(e1.typ));
                chk("m64_illegal", 64'(il1), 64'(e1.ill));
            end
        end
    end

    initial begin
        int n;
        iv    = 3'b000;
        ordy  = 3'b111;
        ins0  = '0;
        ins1  = '0;
        ins2  = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(ov[0]), 64'd0);
        chk("rst_in_ready", 64'(ir[0]), 64'd0);
        chk("rst_type", 64'(t0), 64'd7);
        chk("rst_imm", 64'(imm0), 64'd0);
        chk("rst_illegal", 64'(il0), 64'd0);
        chk("rst_count", 64'(c0), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("release_in_ready", 64'(ir[0]), 64'd1);

        // RV32 stream at full rate, including shift and illegal boundaries
        send(0, 32'hFFF00093, 64'hFFFFFFFF, 3'd0, 1'b0);
        send(0, 32'hFE112E23, 64'hFFFFFFFC, 3'd1, 1'b0);
        send(0, 32'hFE000CE3, 64'hFFFFFFF8, 3'd2, 1'b0);
        send(0, 32'h0010006F, 64'h00000800, 3'd4, 1'b0);
        send(0, 32'h0230D093, 64'h00000003, 3'd0, 1'b0);
        send(0, 32'h0000003B, 64'h0,        3'd7, 1'b1);
        send(0, 32'h00000000, 64'h0,        3'd7, 1'b1);
        send(0, 32'h0000007F, 64'h0,        3'd7, 1'b1);
        idle(0);

        // RV64 decodes
        send(1, 32'h800002B7, 64'hFFFFFFFF80000000, 3'd3, 1'b0);
        send(1, 32'h4030D093, 64'h3,   3'd0, 1'b0);
        send(1, 32'h0000003B, 64'h0,   3'd7, 1'b0);
        send(1, 32'hFFF09073, 64'hFFF, 3'd0, 1'b0);
        send(1, 32'h000FD073, 64'h1F,  3'd5, 1'b0);
        idle(1);

        // 2-bit counter saturation
        repeat (5) send(2, 32'h00000000, 64'h0, 3'd7, 1'b1);
        idle(2);

        repeat (4) @(posedge clk);
        #1;
        chk("count32", 64'(c0), 64'd3);
        chk("count64", 64'(c1), 64'd0);
        chk("count_sat", 64'(c2), 64'd3);

        // Backpressure: A on the outputs, B in the skid
        ordy[0] = 1'b0;
        send(0, 32'h00500093, 64'h5,        3'd0, 1'b0);
        send(0, 32'hFE112E23, 64'hFFFFFFFC, 3'd1, 1'b0);
        idle(0);
        chk("bp_in_ready", 64'(ir[0]), 64'd0);
        chk("bp_out_valid", 64'(ov[0]), 64'd1);
        chk("bp_head_imm", 64'(imm0), 64'h5);
        @(posedge clk); #1;
        chk("bp_hold_imm", 64'(imm0), 64'h5);
        chk("bp_hold_ready", 64'(ir[0]), 64'd0);
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        chk("bp_second_imm", 64'(imm0), 64'hFFFFFFFC);
        chk("bp_ready_back", 64'(ir[0]), 64'd1);
        @(posedge clk); #1;
        chk("bp_drained", 64'(ov[0]), 64'd0);

        // Reset with both entries full discards them
        ordy[0] = 1'b0;
        send(0, 32'h00700093, 64'h7, 3'd0, 1'b0);
        send(0, 32'h00800093, 64'h8, 3'd0, 1'b0);
        idle(0);
        chk("full_before_reset", 64'(ir[0]), 64'd0);
        rst_n = 1'b0;
        q0.delete();
        @(posedge clk); #1;
        chk("mid_rst_out_valid", 64'(ov[0]), 64'd0);
        chk("mid_rst_count", 64'(c0), 64'd0);
        chk("mid_rst_type", 64'(t0), 64'd7);
        chk("mid_rst_in_ready", 64'(ir[0]), 64'd0);
        rst_n   = 1'b1;
        ordy[0] = 1'b1;
        n = 0;
        while (!ir[0] && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("post_rst_in_ready", 64'(ir[0]), 64'd1);
        send(0, 32'h06400093, 64'd100, 3'd0, 1'b0);
        @(posedge clk); #1;
        iv[0] = 1'b0;
        chk("post_rst_latency_valid", 64'(ov[0]), 64'd1);
        chk("post_rst_latency_imm", 64'(imm0), 64'd100);

        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("q32_drained", 64'(q0.size()), 64'd0);
        chk("q64_drained", 64'(q1.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Registered, parametrised RISC-V immediate generator for the decode stage. It accepts one 32-bit instruction per valid/ready handshake and classifies its format. It produces the sign- or zero-extended immediate at XLEN width, flags illegal opcodes and keeps a saturating illegal-instruction count. A 2-entry output buffer (output register plus skid register) decouples it from downstream backpressure, so a pipelined core can use it in place of a purely combinational sign extender.

## Interface
Parameters:
- XLEN, 32: datapath width; legal values are 32 and 64. RV64-only opcodes are illegal when XLEN=32.
- CNT_W, 16: width of the illegal-instruction counter.

Ports:
- clk  in  1  clock; all state is updated on the rising edge.
- reset  in  1  reset, synchronous and active-low.
- in_valid  in  1  an instruction is offered.
- in_ready  out  1  the block can accept an instruction.
- instr  in  32  instruction word.
- out_valid  out  1  the output registers hold a result.
- out_ready  in  1  downstream consumes the result.
- imm  out  XLEN  extended immediate.
- imm_type  out  3  format: I=0, S=1, B=2, U=3, J=4, Z=5, NONE=7.
- illegal  out  1  the instruction is unrecognised.
- illegal_count  out  CNT_W  saturating count of accepted illegal instructions.

## Operation
Transfers:
- An input transfer occurs when in_valid && in_ready.
- An output transfer occurs when out_valid && out_ready.

Decode, from opcode instr[6:0]:
- 0000011 load, 0001111 fence, 1100111 jalr → I: sign-extend instr[31:20].
- 0010011 OP-IMM → I. Exception: when funct3 (instr[14:12]) is 001 or 101, imm is the zero-extended shamt. shamt is instr[25:20] for XLEN=64 and instr[24:20] for XLEN=32, so bit 30 (srai) never reaches imm.
- 0011011 OP-IMM-32 (XLEN=64 only) → I, with the same shamt rule using instr[24:20].
- 0100011 → S: sign-extend {instr[31:25], instr[11:7]}.
- 1100011 → B: sign-extend {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- 0110111 and 0010111 → U: {instr[31:12], 12'b0}, then sign-extended to XLEN.
- 1101111 → J: sign-extend {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- 1110011 SYSTEM: funct3[2]=1 → Z, zero-extend instr[19:15]. funct3 = 001 or 010 or 011 → I with zero-extended instr[31:20] (CSR address). funct3 = 000 → I, sign-extended.
- 0110011, and 0111011 (XLEN=64 only) → NONE, imm=0, legal.
- Any other opcode → illegal=1, imm_type=NONE, imm=0. This includes instr[1:0] ≠ 11.

Counter:
- illegal_count increments on each input transfer whose decode is illegal.
- It saturates at 2^CNT_W−1 and clears only on reset.

## Timing
Reset (reset=0 at a rising edge):
- out_valid=0, skid empty, imm=0, imm_type=NONE, illegal=0, illegal_count=0.
- in_ready is 0 while reset is low and 1 in the first cycle after release.
- A reset asserted mid-operation discards both buffered entries with no output transfer.

Latency and throughput:
- One cycle: an instruction accepted at edge N is visible on the outputs after edge N.
- Full throughput (one instruction per cycle) while out_ready=1.

in_ready:
- in_ready = !skid_valid, driven from a register with no combinational path from out_ready.

Output register loading:
- The output register loads the decoded input when an input transfer occurs and either out_valid=0 or an output transfer occurs in the same cycle.

Skid behaviour:
- When an input transfer occurs while out_valid=1 && out_ready=0, the decoded entry goes to the skid register and in_ready falls next cycle.
- When an output transfer occurs with the skid full, the skid entry moves to the output register and the skid empties.
- No input is accepted in that cycle, because in_ready=0.

Ordering and stability:
- Results leave in acceptance order.
- Outputs hold stable while out_valid=1 && out_ready=0.

## Structure
Shared package (rv_pkg):
- opcode constants.
- imm_type encodings I/S/B/U/J/Z/NONE.

Sub-module imm_decode (combinational, parameter XLEN):
- Maps instr to {imm, imm_type, illegal}.
- Instantiated once, before the buffer.

The top level contains the output register, the skid register and the saturating counter.

## Test plan
- XLEN=32, out_ready=1, stream 0xFFF00093, 0xFE112E23, 0xFE000CE3, 0x0010006F on consecutive cycles → over four consecutive cycles:
  - imm 0xFFFFFFFF, type I
  - imm 0xFFFFFFFC, type S
  - imm 0xFFFFFFF8, type B
  - imm 0x00000800, type J
- XLEN=64: 0x800002B7 (lui) → imm 0xFFFFFFFF80000000, type U. 0x4030D093 (srai x1,x1,3) → imm 3, type I.
- Illegal inputs 0x00000000 then 0x0000007F → illegal=1, imm=0, type NONE, illegal_count=2. With CNT_W=2, five illegal inputs → count stays 3.
- Backpressure: out_ready=0, send A and B → A held on the outputs, B in the skid, in_ready=0. Raise out_ready → A, then B, on consecutive cycles, then in_ready=1.
- Assert reset with both entries full → next cycle out_valid=0, illegal_count=0, imm_type=NONE. After release in_ready=1 and the first new instruction emerges one cycle after acceptance.
